// File: rtl/sub_arbiter_pkg.sv
// Shared types and constants for the two-requester subtract arbiter.
package sub_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ID_W       = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sub_unit.sv
// Combinational a - b with borrow out.
// Build option SUB_ARBITER_SATURATE_EN clamps a negative result to zero.
module sub_unit
    import sub_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] diff_c,
    output logic              borrow_c
);

    logic [DATA_W:0] full_c;

    // The extra top bit of the widened difference is the unsigned borrow.
    assign full_c   = {1'b0, a} - {1'b0, b};
    assign borrow_c = full_c[DATA_W];

`ifdef SUB_ARBITER_SATURATE_EN
    assign diff_c = borrow_c ? '0 : full_c[DATA_W-1:0];
`else
    assign diff_c = full_c[DATA_W-1:0];
`endif

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin front end sharing one subtractor between two requesters.
// Build option SUB_ARBITER_SATURATE_EN selects clamped instead of wrapped results.
module sub_arbiter
    import sub_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_borrow,
    output logic              rsp_id,
    output logic              busy
);

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] op_a_q,       op_a_d;
    logic [DATA_W-1:0] op_b_q,       op_b_d;
    logic [ID_W-1:0]   op_id_q,      op_id_d;
    logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
    logic              rsp_borrow_q, rsp_borrow_d;
    logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;

    logic              grant_c;
    logic              idle_c;
    logic              hs_c;
    logic [DATA_W-1:0] diff_c;
    logic              borrow_c;

    sub_unit #(
        .DATA_W (DATA_W)
    ) u_sub_unit (
        .a        (op_a_q),
        .b        (op_b_q),
        .diff_c   (diff_c),
        .borrow_c (borrow_c)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_c    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        idle_c     = (state_q == IDLE) && !rst;
        req0_ready = idle_c && req0_valid && !grant_c;
        req1_ready = idle_c && req1_valid && grant_c;
        hs_c       = req0_ready || req1_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_borrow_d = rsp_borrow_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    state_d      = EXEC;
                    last_grant_d = grant_c;
                    op_a_d       = grant_c ? req1_a : req0_a;
                    op_b_d       = grant_c ? req1_b : req0_b;
                    op_id_d      = ID_W'(grant_c);
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_data_d   = diff_c;
                rsp_borrow_d = borrow_c;
                rsp_id_d     = op_id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            rsp_data_q   <= '0;
            rsp_borrow_q <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_borrow_q <= rsp_borrow_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_borrow = rsp_borrow_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter: vector table, corner sequences, random ops vs a reference model.
module tb_sub_arbiter;

`ifdef SUB_ARBITER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_borrow;
    logic       rsp_id;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sub_arbiter #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_borrow (rsp_borrow),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_b;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true integer difference, then wrap or clamp.
    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = SAT ? 0 : d + 256;
        return 8'(d);
    endfunction

    task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_op(input string nm, input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb);
        int n;
        drive(id, a, b);
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 10) begin
            step();
            n++;
        end
        chk({nm, " ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({nm, " exec busy"}, 32'(busy), 32'd1);
        chk({nm, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        step();
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " data"}, 32'(rsp_data), 32'(ed));
        chk({nm, " borrow"}, 32'(rsp_borrow), 32'(eb));
        chk({nm, " id"}, 32'(rsp_id), 32'(id));
        step();
        chk({nm, " back idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic       model_last;
        logic       exp_g;
        logic [7:0] ea, eb8, a0, b0, a1, b1;
        int         mask, stall, n, prev;

        vecs[0] = '{id: 1'b1, a: 8'h30, b: 8'h10, exp_d: 8'h20, exp_b: 1'b0};
        vecs[1] = '{id: 1'b0, a: 8'h05, b: 8'h09, exp_d: SAT ? 8'h00 : 8'hFC, exp_b: 1'b1};
        vecs[2] = '{id: 1'b1, a: 8'hFF, b: 8'hFF, exp_d: 8'h00, exp_b: 1'b0};
        vecs[3] = '{id: 1'b0, a: 8'h00, b: 8'h01, exp_d: SAT ? 8'h00 : 8'hFF, exp_b: 1'b1};
        vecs[4] = '{id: 1'b0, a: 8'hFF, b: 8'h00, exp_d: 8'hFF, exp_b: 1'b0};
        vecs[5] = '{id: 1'b1, a: 8'h80, b: 8'h81, exp_d: SAT ? 8'h00 : 8'hFF, exp_b: 1'b1};

        // Reset with a request already pending.
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", 32'(rsp_data), 32'd0);
        chk("rst rsp_borrow", 32'(rsp_borrow), 32'd0);
        chk("rst rsp_id", 32'(rsp_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst req1_ready", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst req0_ready", 32'(req0_ready), 32'd1);
        chk("post-rst req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        chk("first exec busy", 32'(busy), 32'd1);
        step();
        chk("first rsp_valid", 32'(rsp_valid), 32'd1);
        chk("first data", 32'(rsp_data), 32'h1B);
        chk("first id", 32'(rsp_id), 32'd0);
        step();

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_b);
        end

        // Last grant is now 1, so a tie should give 0,1,0,1 with 3-cycle spacing.
        drive(1'b0, 8'h11, 8'h01);
        drive(1'b1, 8'h22, 8'h02);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("fair%0d valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("fair%0d id", k), 32'(rsp_id), 32'(k % 2));
            chk($sformatf("fair%0d data", k), 32'(rsp_data), (k % 2) ? 32'h20 : 32'h10);
            if (k > 0) chk($sformatf("fair%0d spacing", k), 32'(cyc - prev), 32'd3);
            prev = cyc;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure: response held, no new grants while stalled.
        rsp_ready = 1'b0;
        drive(1'b0, 8'h40, 8'h41);
        #1;
        chk("bp ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        drive(1'b0, 8'h01, 8'h01);
        drive(1'b1, 8'h02, 8'h01);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d data", i), 32'(rsp_data), SAT ? 32'h00 : 32'hFF);
            chk($sformatf("bp%0d borrow", i), 32'(rsp_borrow), 32'd1);
            chk($sformatf("bp%0d id", i), 32'(rsp_id), 32'd0);
            chk($sformatf("bp%0d readys", i), 32'({req1_ready, req0_ready}), 32'd0);
            if (i < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp released busy", 32'(busy), 32'd0);
        chk("bp released valid", 32'(rsp_valid), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during EXEC drops the operation.
        drive(1'b1, 8'h09, 8'h03);
        #1;
        chk("mid ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        chk("mid exec busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid quiet%0d", i), 32'({rsp_valid, busy}), 32'd0);
            step();
        end
        drive(1'b0, 8'h07, 8'h02);
        drive(1'b1, 8'h08, 8'h02);
        #1;
        chk("mid tie req0_ready", 32'(req0_ready), 32'd1);
        chk("mid tie req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        chk("mid after data", 32'(rsp_data), 32'h05);
        chk("mid after id", 32'(rsp_id), 32'd0);
        step();
        model_last = 1'b0;

        // Random traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            mask = int'($urandom_range(1, 3));
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            if (mask[0]) drive(1'b0, a0, b0);
            if (mask[1]) drive(1'b1, a1, b1);
            #1;
            exp_g = (mask == 3) ? ~model_last : (mask == 2);
            chk($sformatf("rnd%0d grant", it), 32'({req1_ready, req0_ready}), exp_g ? 32'd2 : 32'd1);
            step();
            model_last = exp_g;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            ea  = exp_g ? a1 : a0;
            eb8 = exp_g ? b1 : b0;
            stall = int'($urandom_range(0, 2));
            rsp_ready = (stall == 0);
            step();
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) rsp_ready = 1'b1;
                chk($sformatf("rnd%0d valid", it), 32'(rsp_valid), 32'd1);
                chk($sformatf("rnd%0d data", it), 32'(rsp_data), 32'(ref_diff(ea, eb8)));
                chk($sformatf("rnd%0d borrow", it), 32'(rsp_borrow), 32'(ea < eb8));
                chk($sformatf("rnd%0d id", it), 32'(rsp_id), 32'(exp_g));
                step();
            end
            chk($sformatf("rnd%0d idle", it), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_arbiter.md
# sub_arbiter

Shares one DATA_W-bit subtract unit between two requesters using round-robin arbitration and valid/ready handshakes, and returns each difference with a borrow flag and requester ID on a single response channel. It sits between the two operand sources and the subtract datapath. It is the sequencing front end for the subtractor that drives uo_out in the TinyTapeout top.

## Interface
- DATA_W, default 8: operand and result width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  minuend and subtrahend for requester n.
- req0_ready / req1_ready  out  1  handshake accept for requester n.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  result, a − b.
- rsp_borrow  out  1  set when a < b (unsigned).
- rsp_id  out  1  requester that issued the operation (0 or 1).
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate among the requesters.
  - EXEC: compute into the result registers.
  - RESP: hold the response until it is accepted.
- Transitions:
  - IDLE→EXEC on a handshake.
  - EXEC→RESP unconditionally.
  - RESP→IDLE when rsp_valid & rsp_ready.
- reqN_ready is combinational. It is high only in IDLE, and only for the granted requester. At most one ready is high in any cycle.
- Arbitration in IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant the requester ≠ last_grant.
  - last_grant updates on each handshake.
- Handshake: on reqN_valid & reqN_ready, latch a, b and the ID into operand registers.
- EXEC registers rsp_data = (a − b) mod 2^DATA_W and rsp_borrow = (a < b).
- The response registers stay stable while rsp_valid & !rsp_ready.
- Requesters hold valid and operands until ready. The arbiter samples them only in IDLE.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - rsp_valid, rsp_data, rsp_borrow, rsp_id, busy and both readys = 0.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced. After release the FSM starts in IDLE.

## Timing
- Handshake at edge N puts the FSM in EXEC for cycle N.
- At edge N+1 the result registers load, the FSM enters RESP and rsp_valid rises.
- With rsp_ready high, edge N+2 returns the FSM to IDLE. The next handshake can occur at edge N+3.
- Peak throughput is one operation per 3 cycles. Latency from handshake to rsp_valid is 1 cycle.
- Back-pressure: each cycle of rsp_ready low extends RESP by one cycle. No new request is accepted during RESP.
- Both requesters continuously valid: grants alternate 0, 1, 0, 1…
- A request arriving while the FSM is busy waits. It is not lost, because the requester holds valid.

## Configuration
- SUB_ARBITER_SATURATE_EN:
  - Defined: when a < b, rsp_data = 0 and rsp_borrow = 1.
  - Undefined: rsp_data wraps modulo 2^DATA_W.
  - rsp_borrow is identical in both builds.

## Structure
- Package sub_arbiter_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - DATA_W default constant;
  - ID width constant.
- One sub-module, sub_unit: combinational a − b with borrow out, and the SATURATE option applied inside it. sub_arbiter instantiates it once.

## Test plan
- Reset: hold rst for 2 cycles → all outputs 0 and busy 0. Then set req0_valid with a=0x20, b=0x05 → req0_ready high in the first cycle after release.
- Single request: req1 with a=0x30, b=0x10 → rsp_valid 1 cycle after the handshake, rsp_data=0x20, rsp_borrow=0, rsp_id=1.
- Borrow: req0 with a=5, b=9 → rsp_data=0xFC, borrow=1. With SUB_ARBITER_SATURATE_EN defined → rsp_data=0x00, borrow=1.
- Fairness: both requesters valid for 4 operations, rsp_ready held 1 → rsp_id sequence 0,1,0,1. Handshakes 3 cycles apart.
- Back-pressure: rsp_ready low for 5 cycles in RESP → rsp_data, rsp_borrow and rsp_id stable, both readys low. Raise rsp_ready → return to IDLE on the next edge.
- Reset mid-operation: assert rst while in EXEC → rsp_valid never rises for that operation, state = IDLE. The next request completes normally.
